// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// pll_lock_sequencer : drives PLL RESET, supervises LOCK, gates downstream reset
// Optional lock-loss glitch filter in RUN: define PLL_SEQ_GLITCH_FILTER_EN
// Rev 1.0
// ============================================================================
module pll_lock_sequencer #(
  parameter int RESET_CYCLES  = 64,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int GLITCH_CYCLES = 4,
  localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pll_lock,
  input  logic            restart_req,
  output logic            pll_reset,
  output logic            out_rst,
  output logic            ready,
  output logic            lock_lost,
  output logic            fault,
  output logic [RC_W-1:0] retry_cnt,
  output logic [2:0]      state
);

  localparam int CNT_MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0]  RETRY_MAX = RC_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RC_W-1:0]   retry_q, retry_d;
  logic              meta_q, meta_d;
  logic              lock_s_q, lock_s_d;
  logic              pll_reset_q, pll_reset_d;
  logic              out_rst_q, out_rst_d;
  logic              ready_q, ready_d;
  logic              lock_lost_q, lock_lost_d;
  logic              fault_q, fault_d;
  logic              cnt_restart;

`ifdef PLL_SEQ_GLITCH_FILTER_EN
  localparam int GL_W = $clog2(GLITCH_CYCLES + 1);
  localparam logic [GL_W-1:0] GL_LAST = GL_W'(GLITCH_CYCLES - 1);
  logic [GL_W-1:0] glitch_q, glitch_d;
`else
  logic unused_glitch_cfg;
  assign unused_glitch_cfg = |GLITCH_CYCLES;
`endif

  always_comb begin
    meta_d      = pll_lock;
    lock_s_d    = meta_q;
    state_d     = state_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    cnt_restart = 1'b0;
`ifdef PLL_SEQ_GLITCH_FILTER_EN
    glitch_d    = '0;
`endif

    if (restart_req) begin
      state_d     = ST_RST_PLL;
      retry_d     = '0;
      cnt_restart = 1'b1;
    end else begin
      case (state_q)
        ST_RST_PLL: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = ST_SETTLE;
          end else if (cnt_q == TMO_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              retry_d = retry_q + RC_W'(1);
              state_d = ST_RST_PLL;
            end
          end
        end
        ST_SETTLE: begin
          // a low lock_s on the final settle cycle still sends us back
          if (!lock_s_q) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STB_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
`ifdef PLL_SEQ_GLITCH_FILTER_EN
          if (!lock_s_q) begin
            if (glitch_q == GL_LAST) begin
              state_d     = ST_RST_PLL;
              lock_lost_d = 1'b1;
            end else begin
              glitch_d = glitch_q + GL_W'(1);
            end
          end
`else
          if (!lock_s_q) begin
            state_d     = ST_RST_PLL;
            lock_lost_d = 1'b1;
          end
`endif
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RST_PLL;
        end
      endcase
    end

    if (cnt_restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == ST_RST_PLL) || (state_q == ST_WAIT_LOCK) ||
                 (state_q == ST_SETTLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // outputs follow the next state so they switch on the same edge as state
    pll_reset_d = (state_d == ST_RST_PLL) || (state_d == ST_FAULT);
    out_rst_d   = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q      <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= ST_RST_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      out_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      fault_q     <= 1'b0;
`ifdef PLL_SEQ_GLITCH_FILTER_EN
      glitch_q    <= '0;
`endif
    end else begin
      meta_q      <= meta_d;
      lock_s_q    <= lock_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      out_rst_q   <= out_rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      fault_q     <= fault_d;
`ifdef PLL_SEQ_GLITCH_FILTER_EN
      glitch_q    <= glitch_d;
`endif
    end
  end

  assign pll_reset = pll_reset_q;
  assign out_rst   = out_rst_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pll_lock_sequencer : directed self-checking bench for pll_lock_sequencer
// Rev 1.0
// ============================================================================
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       restart_req;
  logic       pll_reset;
  logic       out_rst;
  logic       ready;
  logic       lock_lost;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .GLITCH_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .restart_req (restart_req),
    .pll_reset   (pll_reset),
    .out_rst     (out_rst),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .state       (state)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " state"},     32'(state),     32'd0);
    chk({tag, " pll_reset"}, 32'(pll_reset), 32'd1);
    chk({tag, " out_rst"},   32'(out_rst),   32'd1);
    chk({tag, " ready"},     32'(ready),     32'd0);
    chk({tag, " lock_lost"}, 32'(lock_lost), 32'd0);
    chk({tag, " fault"},     32'(fault),     32'd0);
    chk({tag, " retry_cnt"}, 32'(retry_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_state;
    int exp_retry;
    reset = 1'b1; pll_lock = 1'b0; restart_req = 1'b0;
    tick(3);
    chk_reset_vals("reset");

    // Normal lock: t0 is the first WAIT_LOCK cycle
    reset = 1'b0;
    tick(1); chk("nl c1 state", 32'(state), 32'd0); chk("nl c1 pll_reset", 32'(pll_reset), 32'd1);
    tick(2); chk("nl c3 pll_reset", 32'(pll_reset), 32'd1);
    tick(1); chk("nl t0 state", 32'(state), 32'd1); chk("nl t0 pll_reset", 32'(pll_reset), 32'd0);
    pll_lock = 1'b1;
    tick(2); chk("nl t0+2 state", 32'(state), 32'd1);
    tick(1); chk("nl t0+3 state", 32'(state), 32'd2);
    tick(7); chk("nl t0+10 state", 32'(state), 32'd2); chk("nl t0+10 out_rst", 32'(out_rst), 32'd1);
    tick(1); chk("nl t0+11 state", 32'(state), 32'd3); chk("nl t0+11 out_rst", 32'(out_rst), 32'd0);
    chk("nl t0+11 ready", 32'(ready), 32'd1); chk("nl t0+11 retry", 32'(retry_cnt), 32'd0);

    // Lock loss in RUN
`ifndef PLL_SEQ_GLITCH_FILTER_EN
    pll_lock = 1'b0; tick(1); pll_lock = 1'b1;
    tick(1); chk("ll r+2 state", 32'(state), 32'd3); chk("ll r+2 lock_lost", 32'(lock_lost), 32'd0);
    tick(1); chk("ll r+3 state", 32'(state), 32'd0); chk("ll r+3 lock_lost", 32'(lock_lost), 32'd1);
    chk("ll r+3 out_rst", 32'(out_rst), 32'd1); chk("ll r+3 ready", 32'(ready), 32'd0);
    chk("ll r+3 pll_reset", 32'(pll_reset), 32'd1);
    tick(1); chk("ll r+4 lock_lost", 32'(lock_lost), 32'd0); chk("ll r+4 pll_reset", 32'(pll_reset), 32'd1);
    tick(2); chk("ll r+6 pll_reset", 32'(pll_reset), 32'd1);
    tick(1); chk("ll r+7 state", 32'(state), 32'd1); chk("ll r+7 pll_reset", 32'(pll_reset), 32'd0);
    tick(1); chk("ll r+8 state", 32'(state), 32'd2);
    tick(7); chk("ll r+15 state", 32'(state), 32'd2);
    tick(1); chk("ll r+16 state", 32'(state), 32'd3); chk("ll r+16 ready", 32'(ready), 32'd1);
`else
    pll_lock = 1'b0; tick(3); pll_lock = 1'b1;
    tick(3); chk("gf3 state", 32'(state), 32'd3); chk("gf3 lock_lost", 32'(lock_lost), 32'd0);
    tick(2); chk("gf3 late state", 32'(state), 32'd3);
    pll_lock = 1'b0; tick(4); pll_lock = 1'b1;
    tick(1); chk("gf4 r+5 state", 32'(state), 32'd3); chk("gf4 r+5 lock_lost", 32'(lock_lost), 32'd0);
    tick(1); chk("gf4 r+6 state", 32'(state), 32'd0); chk("gf4 r+6 lock_lost", 32'(lock_lost), 32'd1);
    chk("gf4 r+6 out_rst", 32'(out_rst), 32'd1);
    tick(1); chk("gf4 r+7 lock_lost", 32'(lock_lost), 32'd0);
    tick(3); chk("gf4 r+10 state", 32'(state), 32'd1);
    tick(1); chk("gf4 r+11 state", 32'(state), 32'd2);
    tick(8); chk("gf4 r+19 state", 32'(state), 32'd3);
`endif

    // Restart from RUN, then a one-cycle glitch mid-SETTLE
    restart_req = 1'b1; tick(1); restart_req = 1'b0;
    chk("rs s+1 state", 32'(state), 32'd0); chk("rs s+1 lock_lost", 32'(lock_lost), 32'd0);
    chk("rs s+1 out_rst", 32'(out_rst), 32'd1); chk("rs s+1 pll_reset", 32'(pll_reset), 32'd1);
    tick(4); chk("rs s+5 state", 32'(state), 32'd1);
    tick(1); chk("rs s+6 state", 32'(state), 32'd2);
    tick(2); pll_lock = 1'b0;
    tick(1); pll_lock = 1'b1;
    tick(1); chk("sg s+10 state", 32'(state), 32'd2);
    tick(1); chk("sg s+11 state", 32'(state), 32'd1); chk("sg s+11 retry", 32'(retry_cnt), 32'd0);
    tick(1); chk("sg s+12 state", 32'(state), 32'd2);
    tick(7); chk("sg s+19 state", 32'(state), 32'd2);
    tick(1); chk("sg s+20 state", 32'(state), 32'd3);

    // Reset asserted mid-SETTLE
    restart_req = 1'b1; tick(1); restart_req = 1'b0;
    tick(5); chk("rm t+6 state", 32'(state), 32'd2);
    tick(2); reset = 1'b1;
    tick(1); chk_reset_vals("rm");

    // No lock: three reset pulses, 20-cycle waits, then FAULT
    pll_lock = 1'b0;
    tick(2); reset = 1'b0;
    for (int k = 1; k <= 75; k++) begin
      tick(1);
      if (k < 4)       exp_state = 0;
      else if (k < 24) exp_state = 1;
      else if (k < 28) exp_state = 0;
      else if (k < 48) exp_state = 1;
      else if (k < 52) exp_state = 0;
      else if (k < 72) exp_state = 1;
      else             exp_state = 4;
      exp_retry = (k < 24) ? 0 : (k < 48) ? 1 : 2;
      chk($sformatf("nolock k=%0d state", k), 32'(state), 32'(exp_state));
      chk($sformatf("nolock k=%0d pll_reset", k), 32'(pll_reset),
          (exp_state == 1) ? 32'd0 : 32'd1);
      chk($sformatf("nolock k=%0d retry", k), 32'(retry_cnt), 32'(exp_retry));
      chk($sformatf("nolock k=%0d fault", k), 32'(fault), (exp_state == 4) ? 32'd1 : 32'd0);
    end

    // Fault recovery, with lock dropping on the final SETTLE cycle
    pll_lock = 1'b1;
    tick(3); chk("fr hold state", 32'(state), 32'd4); chk("fr hold fault", 32'(fault), 32'd1);
    chk("fr hold out_rst", 32'(out_rst), 32'd1);
    restart_req = 1'b1; tick(1); restart_req = 1'b0;
    chk("fr v+1 state", 32'(state), 32'd0); chk("fr v+1 fault", 32'(fault), 32'd0);
    chk("fr v+1 retry", 32'(retry_cnt), 32'd0); chk("fr v+1 pll_reset", 32'(pll_reset), 32'd1);
    tick(4); chk("fr v+5 state", 32'(state), 32'd1);
    tick(1); chk("fr x state", 32'(state), 32'd2);
    tick(5); pll_lock = 1'b0;
    tick(1); pll_lock = 1'b1;
    tick(1); chk("se x+7 state", 32'(state), 32'd2);
    tick(1); chk("se x+8 state", 32'(state), 32'd1); chk("se x+8 out_rst", 32'(out_rst), 32'd1);
    tick(1); chk("se x+9 state", 32'(state), 32'd2);
    tick(8); chk("se x+17 state", 32'(state), 32'd3); chk("se x+17 ready", 32'(ready), 32'd1);
    chk("se x+17 retry", 32'(retry_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
